// File: rtl/sobel_bus_ctrl_if.sv
// Wishbone-style memory port shared by the Sobel bus sequencer and the memory.
// The master drives cycle, strobe and write enable; the slave returns acknowledge.
interface sobel_bus_ctrl_if;
    logic cyc;
    logic stb;
    logic we;
    logic ack;

    modport master (
        output cyc,
        output stb,
        output we,
        input  ack
    );

    modport slave (
        input  cyc,
        input  stb,
        input  we,
        output ack
    );
endinterface

// File: rtl/sobel_bus_ctrl.sv
// Sobel frame sequencer: for each output word it reads prev/curr/next row words,
// hands off to the datapath, then writes the result word back over the memory bus.
module sobel_bus_ctrl #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned CNT_W  = 19
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    sobel_bus_ctrl_if.master   bus,
    output logic               offset_reset,
    output logic               O_offset_cnt_en,
    output logic               D_offset_cnt_en,
    output logic               prev_row_load,
    output logic               curr_row_load,
    output logic               next_row_load,
    output logic               prev_latch_o,
    output logic               curr_latch_o,
    output logic               next_latch_o,
    output logic               calc_start_o,
    input  logic               calc_done_i
);

    localparam int unsigned Words = (WIDTH / 4) * (HEIGHT - 2);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(Words - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRdPrev,
        StRdCurr,
        StRdNext,
        StCalc,
        StWrite,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             calc_first_q, calc_first_d;
    logic             cyc, stb, we;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            calc_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            calc_first_q <= calc_first_d;
        end
    end

    // Bus and row-load outputs depend on state only, so the address stays put while stb is high.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        calc_first_d    = 1'b0;
        cyc             = 1'b0;
        stb             = 1'b0;
        we              = 1'b0;
        offset_reset    = 1'b0;
        O_offset_cnt_en = 1'b0;
        D_offset_cnt_en = 1'b0;
        prev_row_load   = 1'b0;
        curr_row_load   = 1'b0;
        next_row_load   = 1'b0;
        prev_latch_o    = 1'b0;
        curr_latch_o    = 1'b0;
        next_latch_o    = 1'b0;
        calc_start_o    = 1'b0;
        done_o          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StInit;
            end
            StInit: begin
                offset_reset = 1'b1;
                cnt_d        = '0;
                state_d      = StRdPrev;
            end
            StRdPrev: begin
                cyc           = 1'b1;
                stb           = 1'b1;
                prev_row_load = 1'b1;
                if (bus.ack) begin
                    prev_latch_o = 1'b1;
                    state_d      = StRdCurr;
                end
            end
            StRdCurr: begin
                cyc           = 1'b1;
                stb           = 1'b1;
                curr_row_load = 1'b1;
                if (bus.ack) begin
                    curr_latch_o = 1'b1;
                    state_d      = StRdNext;
                end
            end
            StRdNext: begin
                cyc           = 1'b1;
                stb           = 1'b1;
                next_row_load = 1'b1;
                if (bus.ack) begin
                    next_latch_o    = 1'b1;
                    O_offset_cnt_en = 1'b1;
                    calc_first_d    = 1'b1;
                    state_d         = StCalc;
                end
            end
            StCalc: begin
                // calc_first_q marks the entry cycle so the start pulse is one cycle wide.
                calc_start_o = calc_first_q;
                if (calc_done_i) state_d = StWrite;
            end
            StWrite: begin
                cyc = 1'b1;
                stb = 1'b1;
                we  = 1'b1;
                if (bus.ack) begin
                    D_offset_cnt_en = 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = StRdPrev;
                    end
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o  = (state_q != StIdle);
    assign bus.cyc = cyc;
    assign bus.stb = stb;
    assign bus.we  = we;

endmodule

// File: tb/tb_sobel_bus_ctrl.sv
// Self-checking bench for sobel_bus_ctrl: randomized ack/calc_done timing checked
// against a transaction-level model of the per-word read/read/read/calc/write sequence.
module tb_sobel_bus_ctrl;

    localparam int unsigned W     = 8;
    localparam int unsigned H     = 4;
    localparam int unsigned CW    = 4;
    localparam int          WORDS = (W / 4) * (H - 2);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic calc_done = 1'b0;
    logic busy, done, offset_reset, o_en, d_en;
    logic pl, cl, nl, plat, clat, nlat, cs;
    logic [14:0] all_out;

    sobel_bus_ctrl_if bus ();

    sobel_bus_ctrl #(
        .WIDTH (W),
        .HEIGHT(H),
        .CNT_W (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .busy_o         (busy),
        .done_o         (done),
        .bus            (bus),
        .offset_reset   (offset_reset),
        .O_offset_cnt_en(o_en),
        .D_offset_cnt_en(d_en),
        .prev_row_load  (pl),
        .curr_row_load  (cl),
        .next_row_load  (nl),
        .prev_latch_o   (plat),
        .curr_latch_o   (clat),
        .next_latch_o   (nlat),
        .calc_start_o   (cs),
        .calc_done_i    (calc_done)
    );

    always #5 clk = ~clk;

    assign all_out = {busy, done, bus.cyc, bus.stb, bus.we, offset_reset, o_en, d_en,
                      pl, cl, nl, plat, clat, nlat, cs};

    int compared = 0;
    int mismatched = 0;

    // Observations gathered by drive_frame; judged by each test task.
    int obs_tx[$];
    int obs_latch[$];
    int n_or, n_done, n_cs, n_o, n_d, n_viol, n_curr_hi, t_init, t_done;
    bit timed_out, busy_after;

    // ack_mode: 0 tied high, 1 random wait 0..3, 2 three-cycle wait on curr reads only.
    // calc_wait: >=0 fixed delay, -1 tied high, -2 random 0..6.
    task automatic drive_frame(input int ack_mode, input int calc_wait, input bit spurious,
                               input int pre_idle);
        int ack_cnt, calc_cnt, cyc_n;
        bit pending, in_calc, stb_p, acked_p, seen_done;
        logic [2:0] loads, loads_p, exp_lat;
        obs_tx.delete();
        obs_latch.delete();
        n_or = 0; n_done = 0; n_cs = 0; n_o = 0; n_d = 0; n_viol = 0; n_curr_hi = 0;
        t_init = -1; t_done = -1;
        pending = 0; in_calc = 0; stb_p = 0; acked_p = 0; seen_done = 0;
        loads_p = '0; cyc_n = 0; ack_cnt = 0; calc_cnt = 0;
        for (int i = 0; i < pre_idle; i++) begin
            @(negedge clk);
            start     = 1'b0;
            bus.ack   = spurious ? 1'($urandom % 2) : 1'b0;
            calc_done = spurious ? 1'($urandom % 2) : 1'b0;
            #1;
            if (all_out !== '0) n_viol++;
        end
        while (!seen_done && cyc_n < 3000) begin
            @(negedge clk);
            start = (cyc_n == 0) ? 1'b1 : ((spurious && busy) ? 1'($urandom % 2) : 1'b0);
            if (ack_mode == 0) begin
                bus.ack = 1'b1;
            end else if (bus.stb) begin
                if (!pending) begin
                    pending = 1;
                    ack_cnt = (ack_mode == 1) ? int'($urandom % 4) : (cl ? 3 : 0);
                end
                bus.ack = (ack_cnt == 0);
                if (ack_cnt > 0) ack_cnt--;
            end else begin
                bus.ack = spurious ? 1'($urandom % 2) : 1'b0;
            end
            if (bus.ack && bus.stb) pending = 0;
            if (cs) begin
                in_calc  = 1;
                calc_cnt = (calc_wait == -2) ? int'($urandom % 7) : calc_wait;
            end
            if (bus.stb) in_calc = 0;
            if (calc_wait == -1) begin
                calc_done = 1'b1;
            end else if (in_calc) begin
                calc_done = (calc_cnt == 0);
                if (calc_cnt > 0) calc_cnt--;
            end else begin
                calc_done = spurious ? 1'($urandom % 2) : 1'b0;
            end
            #1;
            cyc_n++;
            loads = {pl, cl, nl};
            if (offset_reset) begin n_or++; t_init = cyc_n; end
            if (done) begin n_done++; t_done = cyc_n; seen_done = 1; end
            if (cs) n_cs++;
            if (o_en) n_o++;
            if (d_en) n_d++;
            if (cl) n_curr_hi++;
            if (bus.stb && bus.ack) obs_tx.push_back(bus.we ? 3 : (pl ? 0 : (cl ? 1 : 2)));
            if (plat) obs_latch.push_back(0);
            if (clat) obs_latch.push_back(1);
            if (nlat) obs_latch.push_back(2);
            if (bus.cyc !== bus.stb) n_viol++;
            if (bus.we && !bus.stb) n_viol++;
            if (bus.stb && !bus.we) begin
                if (!$onehot(loads)) n_viol++;
            end else if (loads !== 3'b000) begin
                n_viol++;
            end
            exp_lat = (bus.stb && !bus.we && bus.ack) ? loads : 3'b000;
            if ({plat, clat, nlat} !== exp_lat) n_viol++;
            if (o_en !== (bus.stb && !bus.we && nl && bus.ack)) n_viol++;
            if (d_en !== (bus.stb && bus.we && bus.ack)) n_viol++;
            if (stb_p && bus.stb && !acked_p && loads !== loads_p) n_viol++;
            if (busy !== (cyc_n > 1)) n_viol++;
            stb_p   = bus.stb;
            acked_p = bus.stb && bus.ack;
            loads_p = loads;
        end
        timed_out = !seen_done;
        @(negedge clk);
        start = 1'b0; bus.ack = 1'b0; calc_done = 1'b0;
        #1;
        busy_after = busy;
        if (done) n_viol++;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; bus.ack = 1'b0; calc_done = 1'b0;
        #1 rst = 1'b1;
        #1;
        compared++;
        if (all_out !== '0) begin
            mismatched++; $display("FAIL reset_outputs: got %b want 0", all_out);
        end
        @(negedge clk);
        start = 1'b1; bus.ack = 1'b1; calc_done = 1'b1;
        #1;
        compared++;
        if (all_out !== '0) begin
            mismatched++; $display("FAIL reset_held_start: got %b want 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (all_out !== '0) begin
            mismatched++; $display("FAIL idle_ignores_ack: got %b want 0", all_out);
        end
        bus.ack = 1'b0; calc_done = 1'b0;
    endtask

    task automatic test_zero_wait;
        drive_frame(0, -1, 0, 0);
        compared++;
        if (timed_out) begin mismatched++; $display("FAIL zw_timeout: got 1 want 0"); end
        compared++;
        if (n_or !== 1) begin mismatched++; $display("FAIL zw_offset_reset: got %0d want 1", n_or); end
        compared++;
        if (t_done - t_init !== 1 + 5 * WORDS) begin
            mismatched++;
            $display("FAIL zw_done_latency: got %0d want %0d", t_done - t_init, 1 + 5 * WORDS);
        end
        compared++;
        if (n_o !== WORDS || n_d !== WORDS) begin
            mismatched++; $display("FAIL zw_offset_en: got O=%0d D=%0d want %0d", n_o, n_d, WORDS);
        end
        compared++;
        if (n_viol !== 0) begin mismatched++; $display("FAIL zw_protocol: got %0d want 0", n_viol); end
        compared++;
        if (busy_after !== 1'b0) begin mismatched++; $display("FAIL zw_busy_after: got 1 want 0"); end
    endtask

    task automatic test_random_frame;
        drive_frame(1, -2, 0, 0);
        compared++;
        if (timed_out) begin mismatched++; $display("FAIL rnd_timeout: got 1 want 0"); end
        compared++;
        if (obs_tx.size() !== 4 * WORDS) begin
            mismatched++; $display("FAIL rnd_tx_count: got %0d want %0d", obs_tx.size(), 4 * WORDS);
        end
        for (int i = 0; i < obs_tx.size() && i < 4 * WORDS; i++) begin
            compared++;
            if (obs_tx[i] !== i % 4) begin
                mismatched++; $display("FAIL rnd_tx_order[%0d]: got %0d want %0d", i, obs_tx[i], i % 4);
            end
        end
        compared++;
        if (obs_latch.size() !== 3 * WORDS) begin
            mismatched++;
            $display("FAIL rnd_latch_count: got %0d want %0d", obs_latch.size(), 3 * WORDS);
        end
        for (int i = 0; i < obs_latch.size() && i < 3 * WORDS; i++) begin
            compared++;
            if (obs_latch[i] !== i % 3) begin
                mismatched++;
                $display("FAIL rnd_latch_order[%0d]: got %0d want %0d", i, obs_latch[i], i % 3);
            end
        end
        compared++;
        if (n_o !== WORDS || n_d !== WORDS || n_cs !== WORDS || n_done !== 1) begin
            mismatched++;
            $display("FAIL rnd_counts: got O=%0d D=%0d cs=%0d done=%0d want %0d/%0d/%0d/1",
                     n_o, n_d, n_cs, n_done, WORDS, WORDS, WORDS);
        end
        compared++;
        if (n_viol !== 0) begin mismatched++; $display("FAIL rnd_protocol: got %0d want 0", n_viol); end
    endtask

    task automatic test_curr_stall;
        drive_frame(2, 5, 0, 0);
        compared++;
        if (timed_out) begin mismatched++; $display("FAIL stall_timeout: got 1 want 0"); end
        compared++;
        if (n_curr_hi !== 4 * WORDS) begin
            mismatched++; $display("FAIL stall_curr_load: got %0d want %0d", n_curr_hi, 4 * WORDS);
        end
        compared++;
        if (n_cs !== WORDS) begin
            mismatched++; $display("FAIL stall_calc_start: got %0d want %0d", n_cs, WORDS);
        end
        compared++;
        if (t_done - t_init !== 1 + 13 * WORDS) begin
            mismatched++;
            $display("FAIL stall_latency: got %0d want %0d", t_done - t_init, 1 + 13 * WORDS);
        end
        compared++;
        if (n_viol !== 0) begin mismatched++; $display("FAIL stall_protocol: got %0d want 0", n_viol); end
    endtask

    task automatic test_spurious;
        drive_frame(1, -2, 1, 6);
        compared++;
        if (timed_out) begin mismatched++; $display("FAIL spur_timeout: got 1 want 0"); end
        compared++;
        if (obs_latch.size() !== 3 * WORDS || obs_tx.size() !== 4 * WORDS) begin
            mismatched++;
            $display("FAIL spur_tx: got latch=%0d tx=%0d want %0d/%0d",
                     obs_latch.size(), obs_tx.size(), 3 * WORDS, 4 * WORDS);
        end
        compared++;
        if (n_o !== WORDS || n_d !== WORDS || n_done !== 1 || n_or !== 1) begin
            mismatched++;
            $display("FAIL spur_counts: got O=%0d D=%0d done=%0d init=%0d want %0d/%0d/1/1",
                     n_o, n_d, n_done, n_or, WORDS, WORDS);
        end
        compared++;
        if (n_viol !== 0) begin mismatched++; $display("FAIL spur_protocol: got %0d want 0", n_viol); end
        compared++;
        if (busy_after !== 1'b0) begin mismatched++; $display("FAIL spur_busy_after: got 1 want 0"); end
    endtask

    task automatic test_reset_mid_write;
        bit found;
        found = 0;
        @(negedge clk);
        start = 1'b1; bus.ack = 1'b0; calc_done = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.stb && bus.we) begin
                found = 1;
                bus.ack = 1'b0;
            end else begin
                bus.ack = bus.stb;
            end
        end
        compared++;
        if (!found) begin mismatched++; $display("FAIL rstw_reach_write: got 0 want 1"); end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        compared++;
        if (all_out !== '0) begin
            mismatched++; $display("FAIL rstw_async_outputs: got %b want 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0; bus.ack = 1'b0; calc_done = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rstw_idle: got busy=%b want 0", busy); end
        drive_frame(1, -2, 0, 2);
        compared++;
        if (timed_out) begin mismatched++; $display("FAIL rstw_timeout: got 1 want 0"); end
        compared++;
        if (obs_tx.size() !== 4 * WORDS || n_o !== WORDS || n_d !== WORDS || n_done !== 1) begin
            mismatched++;
            $display("FAIL rstw_counts: got tx=%0d O=%0d D=%0d done=%0d want %0d/%0d/%0d/1",
                     obs_tx.size(), n_o, n_d, n_done, 4 * WORDS, WORDS, WORDS);
        end
        compared++;
        if (n_viol !== 0) begin mismatched++; $display("FAIL rstw_protocol: got %0d want 0", n_viol); end
    endtask

    initial begin
        bus.ack = 1'b0;
        test_reset();
        test_zero_wait();
        test_random_frame();
        test_random_frame();
        test_curr_stall();
        test_spurious();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
